// File: rtl/fixed_stream_join.sv
`default_nettype none
// =============================================================================
// Module  : fixed_stream_join
// Brief   : Pairs two valid/ready operand streams through per-channel FIFOs
//           into one registered {A,B} output slot with a merged last flag.
//           Optional macro JOIN_LAST_CHECK_EN enables the sticky A/B last check.
// Revision: 1.0 - initial release
// =============================================================================
module fixed_stream_join #(
  parameter int WI1   = 4,
  parameter int WF1   = 8,
  parameter int WI2   = 3,
  parameter int WF2   = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WI1+WF1-1:0]   A_data,
  input  logic                 A_valid,
  output logic                 A_ready,
  input  logic                 A_last,
  input  logic [WI2+WF2-1:0]   B_data,
  input  logic                 B_valid,
  output logic                 B_ready,
  input  logic                 B_last,
  output logic [WI1+WF1-1:0]   P_a_data,
  output logic [WI2+WF2-1:0]   P_b_data,
  output logic                 P_valid,
  input  logic                 P_ready,
  output logic                 P_last,
  output logic [CNT_W-1:0]     pair_count,
  output logic                 last_mismatch
);

  localparam int              C_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              C_WA      = WI1 + WF1;
  localparam int              C_WB      = WI2 + WF2;
  localparam logic [C_AW:0]   C_FULL    = (C_AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  // Each FIFO entry is {last, data}
  logic [C_WA:0]   r_a_mem [DEPTH];
  logic [C_AW-1:0] r_a_wp, r_a_rp;
  logic [C_AW:0]   r_a_cnt;
  logic [C_WB:0]   r_b_mem [DEPTH];
  logic [C_AW-1:0] r_b_wp, r_b_rp;
  logic [C_AW:0]   r_b_cnt;

  logic          w_a_push, w_b_push, w_load, w_p_fire;
  logic [C_WA:0] w_a_head;
  logic [C_WB:0] w_b_head;

  assign A_ready  = !reset && (r_a_cnt != C_FULL);
  assign B_ready  = !reset && (r_b_cnt != C_FULL);
  assign w_a_push = A_valid && A_ready;
  assign w_b_push = B_valid && B_ready;
  assign w_a_head = r_a_mem[r_a_rp];
  assign w_b_head = r_b_mem[r_b_rp];
  assign w_p_fire = P_valid && P_ready;
  // Counts only reflect last cycle's pushes, so there is no bypass path.
  assign w_load   = (r_a_cnt != '0) && (r_b_cnt != '0) && (!P_valid || P_ready);

  always_ff @(posedge clk) begin
    if (w_a_push) r_a_mem[r_a_wp] <= {A_last, A_data};
    if (w_b_push) r_b_mem[r_b_wp] <= {B_last, B_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_wp  <= '0;
      r_a_rp  <= '0;
      r_a_cnt <= '0;
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_a_push) r_a_wp <= r_a_wp + C_AW'(1);
      if (w_b_push) r_b_wp <= r_b_wp + C_AW'(1);
      if (w_load) begin
        r_a_rp <= r_a_rp + C_AW'(1);
        r_b_rp <= r_b_rp + C_AW'(1);
      end
      case ({w_a_push, w_load})
        2'b10:   r_a_cnt <= r_a_cnt + (C_AW + 1)'(1);
        2'b01:   r_a_cnt <= r_a_cnt - (C_AW + 1)'(1);
        default: r_a_cnt <= r_a_cnt;
      endcase
      case ({w_b_push, w_load})
        2'b10:   r_b_cnt <= r_b_cnt + (C_AW + 1)'(1);
        2'b01:   r_b_cnt <= r_b_cnt - (C_AW + 1)'(1);
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      P_valid  <= 1'b0;
      P_a_data <= '0;
      P_b_data <= '0;
      P_last   <= 1'b0;
    end else if (w_load) begin
      P_valid  <= 1'b1;
      P_a_data <= w_a_head[C_WA-1:0];
      P_b_data <= w_b_head[C_WB-1:0];
      P_last   <= w_a_head[C_WA] | w_b_head[C_WB];
    end else if (w_p_fire) begin
      P_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_count <= '0;
    end else if (w_p_fire) begin
      if (P_last)
        pair_count <= '0;
      else if (pair_count != C_CNT_MAX)
        pair_count <= pair_count + CNT_W'(1);
    end
  end

`ifdef JOIN_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      last_mismatch <= 1'b0;
    else if (w_load && (w_a_head[C_WA] != w_b_head[C_WB]))
      last_mismatch <= 1'b1;
  end
`else
  assign last_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixed_stream_join.sv
`default_nettype none
// =============================================================================
// Module  : tb_fixed_stream_join
// Brief   : Directed self-checking bench for fixed_stream_join (CNT_W = 4).
// Revision: 1.0 - initial release
// =============================================================================
module tb_fixed_stream_join;
  localparam int WA = 12;
  localparam int WB = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WA-1:0] A_data = '0;
  logic          A_valid = 1'b0, A_last = 1'b0;
  logic          A_ready;
  logic [WB-1:0] B_data = '0;
  logic          B_valid = 1'b0, B_last = 1'b0;
  logic          B_ready;
  logic [WA-1:0] P_a_data;
  logic [WB-1:0] P_b_data;
  logic          P_valid, P_last, last_mismatch;
  logic          P_ready = 1'b1;
  logic [CW-1:0] pair_count;

  fixed_stream_join #(
    .WI1(4), .WF1(8), .WI2(3), .WF2(5), .DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready), .A_last(A_last),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready), .B_last(B_last),
    .P_a_data(P_a_data), .P_b_data(P_b_data), .P_valid(P_valid),
    .P_ready(P_ready), .P_last(P_last), .pair_count(pair_count),
    .last_mismatch(last_mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pairs seen downstream during the latest run
  logic [WA-1:0] obs_a   [64];
  logic [WB-1:0] obs_b   [64];
  logic          obs_last[64];
  logic [CW-1:0] obs_cnt [64];
  logic          obs_mm  [64];
  int            obs_cyc [64];
  int            n_obs, first_joint, first_pv, probe_ia;
  logic          probe_ar, probe_br, probe_pv, timed_out;
  logic [WA-1:0] probe_pa;

  // Drives both producers and the consumer; records, never judges.
  task automatic run(input int na, nb, a_dly, b_dly, p_hold, a_last_at, b_last_at,
                     n_expect, probe_c, input logic [WA-1:0] a_base,
                     input logic [WB-1:0] b_base);
    int ia = 0;
    int ib = 0;
    int c  = 0;
    n_obs = 0; first_joint = -1; first_pv = -1; timed_out = 1'b0;
    while (!(ia >= na && ib >= nb && n_obs >= n_expect)) begin
      if (c >= 300) begin timed_out = 1'b1; break; end
      A_valid = (ia < na) && (c >= a_dly);
      A_data  = a_base + WA'(ia);
      A_last  = (ia == a_last_at);
      B_valid = (ib < nb) && (c >= b_dly);
      B_data  = b_base + WB'(ib);
      B_last  = (ib == b_last_at);
      P_ready = (c >= p_hold);
      @(negedge clk);
      if (c == probe_c) begin
        probe_ar = A_ready; probe_br = B_ready; probe_pv = P_valid;
        probe_pa = P_a_data; probe_ia = ia;
      end
      if (P_valid && first_pv < 0) first_pv = c;
      if (A_valid && A_ready && B_valid && B_ready && first_joint < 0) first_joint = c;
      if (P_valid && P_ready && n_obs < 64) begin
        obs_a[n_obs] = P_a_data; obs_b[n_obs] = P_b_data; obs_last[n_obs] = P_last;
        obs_cnt[n_obs] = pair_count; obs_mm[n_obs] = last_mismatch; obs_cyc[n_obs] = c;
        n_obs++;
      end
      if (A_valid && A_ready) ia++;
      if (B_valid && B_ready) ib++;
      @(posedge clk); #1;
      c++;
    end
    A_valid = 1'b0; B_valid = 1'b0; A_last = 1'b0; B_last = 1'b0; P_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({P_valid, P_last, pair_count, last_mismatch, A_ready, B_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {P_valid, P_last, pair_count, last_mismatch, A_ready, B_ready});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({A_ready, B_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b required 11", {A_ready, B_ready});
    end
  endtask

  task automatic test_stream();
    run(4, 4, 0, 0, 0, 3, 3, 4, -1, 12'h010, 8'h20);
    checks++;
    if (timed_out || n_obs != 4) begin
      errors++; $display("FAIL stream_count: got %0d pairs required 4", n_obs);
    end
    checks++;
    if (first_pv - first_joint != 2) begin
      errors++; $display("FAIL stream_latency: got %0d required 2", first_pv - first_joint);
    end
    checks++;
    if (obs_cyc[3] - obs_cyc[0] != 3) begin
      errors++; $display("FAIL stream_throughput: got %0d required 3", obs_cyc[3] - obs_cyc[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({obs_a[i], obs_b[i], obs_last[i], obs_cnt[i]} !==
          {12'h010 + WA'(i), 8'h20 + WB'(i), (i == 3), CW'(i)}) begin
        errors++;
        $display("FAIL stream_pair%0d: got a=%h b=%h last=%b cnt=%0d required a=%h b=%h last=%b cnt=%0d",
                 i, obs_a[i], obs_b[i], obs_last[i], obs_cnt[i],
                 12'h010 + WA'(i), 8'h20 + WB'(i), (i == 3), i);
      end
    end
    checks++;
    if (pair_count !== '0) begin
      errors++; $display("FAIL stream_count_clear: got %0d required 0", pair_count);
    end
  endtask

  task automatic test_skew();
    run(4, 4, 0, 8, 0, 3, 3, 4, 6, 12'h100, 8'h40);
    checks++;
    if ({probe_ar, probe_pv} !== 2'b00) begin
      errors++; $display("FAIL skew_stall: got ready,valid=%b required 00", {probe_ar, probe_pv});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({obs_a[i], obs_b[i]} !== {12'h100 + WA'(i), 8'h40 + WB'(i)}) begin
        errors++;
        $display("FAIL skew_pair%0d: got a=%h b=%h required a=%h b=%h",
                 i, obs_a[i], obs_b[i], 12'h100 + WA'(i), 8'h40 + WB'(i));
      end
    end
    checks++;
    if (timed_out || A_ready !== 1'b1) begin
      errors++; $display("FAIL skew_ready_return: got %b required 1", A_ready);
    end
  endtask

  task automatic test_backpressure();
    run(8, 8, 0, 0, 12, 7, 7, 8, 10, 12'h200, 8'h60);
    checks++;
    if ({probe_ar, probe_br, probe_pv} !== 3'b001 || probe_ia != 5 || probe_pa !== 12'h200) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b%b pv=%b beats=%0d pa=%h required rdy=00 pv=1 beats=5 pa=200",
               probe_ar, probe_br, probe_pv, probe_ia, probe_pa);
    end
    checks++;
    if (timed_out || n_obs != 8) begin
      errors++; $display("FAIL bp_count: got %0d pairs required 8", n_obs);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({obs_a[i], obs_b[i], obs_last[i]} !== {12'h200 + WA'(i), 8'h60 + WB'(i), (i == 7)}) begin
        errors++;
        $display("FAIL bp_pair%0d: got a=%h b=%h last=%b required a=%h b=%h last=%b",
                 i, obs_a[i], obs_b[i], obs_last[i], 12'h200 + WA'(i), 8'h60 + WB'(i), (i == 7));
      end
    end
  endtask

  task automatic test_saturation();
    run(22, 22, 0, 0, 0, 21, 21, 22, -1, 12'h300, 8'h80);
    checks++;
    if (timed_out || n_obs != 22) begin
      errors++; $display("FAIL sat_count: got %0d pairs required 22", n_obs);
    end
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (obs_cnt[i] !== CW'((i > 15) ? 15 : i)) begin
        errors++;
        $display("FAIL sat_cnt%0d: got %0d required %0d", i, obs_cnt[i], (i > 15) ? 15 : i);
      end
    end
    checks++;
    if (pair_count !== '0) begin
      errors++; $display("FAIL sat_clear: got %0d required 0", pair_count);
    end
  endtask

  task automatic test_last_mismatch();
    logic [3:0] exp_mm;
`ifdef JOIN_LAST_CHECK_EN
    exp_mm = 4'b1110;
`else
    exp_mm = 4'b0000;
`endif
    run(4, 4, 0, 0, 0, 1, 2, 4, -1, 12'h400, 8'hA0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({obs_last[i], obs_mm[i], obs_cnt[i]} !==
          {(i == 1 || i == 2), exp_mm[i], CW'((i == 1) ? 1 : 0)}) begin
        errors++;
        $display("FAIL mm_pair%0d: got last=%b mm=%b cnt=%0d required last=%b mm=%b cnt=%0d",
                 i, obs_last[i], obs_mm[i], obs_cnt[i], (i == 1 || i == 2), exp_mm[i],
                 (i == 1) ? 1 : 0);
      end
    end
    checks++;
    if (last_mismatch !== exp_mm[3]) begin
      errors++; $display("FAIL mm_sticky: got %b required %b", last_mismatch, exp_mm[3]);
    end
  endtask

  task automatic test_reset_mid_packet();
    run(3, 3, 0, 0, 100, -1, -1, 0, -1, 12'h500, 8'hC0);
    P_ready = 1'b0;
    checks++;
    if (P_valid !== 1'b1 || P_a_data !== 12'h500) begin
      errors++; $display("FAIL midrst_pre: got pv=%b pa=%h required pv=1 pa=500", P_valid, P_a_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({P_valid, P_a_data, P_b_data, P_last, pair_count, last_mismatch, A_ready, B_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got pv=%b pa=%h pb=%h pl=%b cnt=%0d mm=%b rdy=%b%b required all 0",
               P_valid, P_a_data, P_b_data, P_last, pair_count, last_mismatch, A_ready, B_ready);
    end
    reset = 1'b0;
    P_ready = 1'b1;
    @(posedge clk); #1;
    run(2, 2, 0, 0, 0, 1, 1, 2, -1, 12'h600, 8'hE0);
    checks++;
    if (timed_out || n_obs != 2) begin
      errors++; $display("FAIL midrst_count: got %0d pairs required 2", n_obs);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({obs_a[i], obs_b[i], obs_last[i], obs_mm[i]} !==
          {12'h600 + WA'(i), 8'hE0 + WB'(i), (i == 1), 1'b0}) begin
        errors++;
        $display("FAIL midrst_pair%0d: got a=%h b=%h last=%b mm=%b required a=%h b=%h last=%b mm=0",
                 i, obs_a[i], obs_b[i], obs_last[i], obs_mm[i], 12'h600 + WA'(i),
                 8'hE0 + WB'(i), (i == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skew();
    test_backpressure();
    test_saturation();
    test_last_mismatch();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
